i2c_sensor_seq: RTL and testbench
=================================

I2C_SENSOR_SEQ -- requirements
Module: i2c_sensor_seq

Interface
REQ-001 Parameter SLAVE_ADDR, default 7'h40, meaning 7-bit I2C address of the temperature/humidity sensor.
REQ-002 Parameter MEAS_CMD, default 8'hE3, meaning command byte written before each 2-byte read.
REQ-003 Parameter PRESCALE, default 16'd99, meaning value written to core prescaler (lo/hi bytes).
REQ-004 Parameter MAX_POLL, default 16'hFFFF, meaning status polls allowed per byte before timeout.
REQ-005 i_clk  in  1  single system clock; i_rst  in  1  reset, asynchronous, active-high.
REQ-006 i_start  in  1  one-cycle request for one measurement.
REQ-007 o_wb_adr  out  5  byte address to I2C master core (register index on bits [4:2]).
REQ-008 o_wb_dat  out  32  write data, bits [31:8] always zero.
REQ-009 o_wb_we  out  1  write enable; o_wb_stb  out  1  strobe (also serves as cyc).
REQ-010 i_wb_rdt  in  32  read data, only [7:0] used; i_wb_ack  in  1  transfer acknowledge.
REQ-011 o_busy  out  1  sequence in progress; o_data  out  16  last result {MSB,LSB}.
REQ-012 o_valid  out  1  one-cycle pulse when o_data updated; o_err  out  1  one-cycle pulse on NACK or timeout.

Function
REQ-013 Core register byte addresses SHALL be PRERlo 0x00, PRERhi 0x04, CTR 0x08, TXR/RXR 0x0C, CR/SR 0x10.
REQ-014 Each bus access SHALL assert o_wb_stb with stable adr/dat/we until i_wb_ack, deassert stb the cycle after ack, with one access outstanding maximum.
REQ-015 After reset the block SHALL run INIT: write PRESCALE[7:0] to 0x00, PRESCALE[15:8] to 0x04, 0x80 to 0x08, then enter IDLE; o_busy high during INIT.
REQ-016 In IDLE, i_start SHALL begin a measurement next cycle; i_start during INIT or while busy SHALL be ignored (not queued).
REQ-017 Measurement step order: TXR={SLAVE_ADDR,0}, CR=0x90; TXR=MEAS_CMD, CR=0x10; TXR={SLAVE_ADDR,1}, CR=0x90; CR=0x20, read RXR->MSB; CR=0x68, read RXR->LSB; then IDLE.
REQ-018 After every CR write the block SHALL poll SR (read 0x10) until bit1 (TIP)=0 before the next step.
REQ-019 After each of the three write-phase polls, SR bit7 (RxACK)=1 SHALL abort: write CR=0x40 (STO), poll TIP clear, pulse o_err, return to IDLE, o_data unchanged.
REQ-020 A poll counter SHALL reset on each CR write; reaching MAX_POLL reads with TIP=1 SHALL pulse o_err and go to IDLE without STO.
REQ-021 On the final LSB read ack, o_data SHALL load {MSB,LSB} and o_valid SHALL pulse the same cycle o_busy falls.
REQ-022 States: INIT_PRL, INIT_PRH, INIT_CTR, IDLE, WR_TXR, WR_CR, POLL, RD_RXR, ABORT_STO, ABORT_POLL; a step index selects TXR/CR values.
REQ-023 o_valid and o_err SHALL never pulse in the same cycle.

Reset
REQ-024 On i_rst assertion, asynchronously: o_wb_stb=0, o_wb_we=0, o_wb_adr=0, o_wb_dat=0, o_data=0, o_valid=0, o_err=0, o_busy=1, state=INIT_PRL.
REQ-025 Reset mid-access SHALL drop stb immediately; any late i_wb_ack after reset release, before the first new stb, SHALL be ignored.

Structure
REQ-026 Register addresses, CR command constants (0x90, 0x10, 0x20, 0x68, 0x40, 0x80) and SR bit positions SHALL live in shared package i2c_core_pkg.
REQ-027 One sub-module, wb_single_master, SHALL implement the REQ-014 handshake; the FSM SHALL be in i2c_sensor_seq.

Verification
REQ-028 Reset release with a 1-cycle-ack slave model -> writes 0x63@0x00, 0x00@0x04, 0x80@0x08 in order, then o_busy=0.
REQ-029 i_start, slave model returns TIP=0/RxACK=0, RXR bytes 0x66 then 0x4C -> writes 0x80,0x90,0xE3,0x10,0x81,0x90,0x20,0x68 in order, o_data=16'h664C, one o_valid pulse.
REQ-030 SR RxACK=1 after first address byte -> CR=0x40 written, o_err one pulse, no o_valid, o_data unchanged.
REQ-031 Ack delayed 5 cycles and TIP=1 for 3 polls -> stb held stable 6 cycles per access, exactly 4 SR reads per byte.
REQ-032 MAX_POLL=4, TIP stuck at 1 -> o_err after 4 SR reads, o_busy=0; i_start pulsed while busy -> no second measurement.
REQ-033 i_rst asserted during POLL -> stb=0 same cycle, INIT sequence restarts after release.

Source files
------------

// File: rtl/i2c_core_pkg.sv
// Register map, command bytes and status bits of the Wishbone I2C master core,
// shared by the measurement sequencer and its bus front end.
package i2c_core_pkg;

    localparam logic [4:0] ADR_PRERLO = 5'h00;
    localparam logic [4:0] ADR_PRERHI = 5'h04;
    localparam logic [4:0] ADR_CTR    = 5'h08;
    localparam logic [4:0] ADR_TXR    = 5'h0C; // RXR when read
    localparam logic [4:0] ADR_CR     = 5'h10; // SR when read

    localparam logic [7:0] CTR_EN        = 8'h80;
    localparam logic [7:0] CR_STA_WR     = 8'h90;
    localparam logic [7:0] CR_WR         = 8'h10;
    localparam logic [7:0] CR_RD         = 8'h20;
    localparam logic [7:0] CR_RD_NAK_STO = 8'h68;
    localparam logic [7:0] CR_STO        = 8'h40;

    localparam int SR_TIP   = 1;
    localparam int SR_RXACK = 7;

    typedef enum logic [3:0] {
        INIT_PRL,
        INIT_PRH,
        INIT_CTR,
        IDLE,
        WR_TXR,
        WR_CR,
        POLL,
        RD_RXR,
        ABORT_STO,
        ABORT_POLL
    } seq_state_t;

    // Steps 0..2 address/command writes, 3 reads MSB with ACK, 4 reads LSB with NACK+STOP.
    function automatic logic [7:0] cr_for_step(input logic [2:0] step);
        case (step)
            3'd0, 3'd2: cr_for_step = CR_STA_WR;
            3'd1:       cr_for_step = CR_WR;
            3'd3:       cr_for_step = CR_RD;
            default:    cr_for_step = CR_RD_NAK_STO;
        endcase
    endfunction

endpackage

// File: rtl/wb_single_master.sv
// Single-outstanding Wishbone master: holds adr/dat/we with stb until ack,
// drops stb the cycle after ack, and ignores any ack seen while idle.
module wb_single_master (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [4:0]  i_adr,
    input  logic [7:0]  i_dat,
    output logic        o_ack,
    output logic [7:0]  o_rdt,
    output logic [4:0]  o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic        o_wb_we,
    output logic        o_wb_stb,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack
);

    logic       r_stb;
    logic       r_we;
    logic [4:0] r_adr;
    logic [7:0] r_dat;
    logic       w_unused;

    assign o_ack    = r_stb & i_wb_ack;
    assign o_rdt    = i_wb_rdt[7:0];
    assign o_wb_adr = r_adr;
    assign o_wb_dat = {24'd0, r_dat};
    assign o_wb_we  = r_we;
    assign o_wb_stb = r_stb;
    assign w_unused = ^i_wb_rdt[31:8];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stb <= 1'b0;
            r_we  <= 1'b0;
            r_adr <= '0;
            r_dat <= '0;
        end else if (r_stb) begin
            if (i_wb_ack) begin
                r_stb <= 1'b0;
            end
        end else if (i_req) begin
            r_stb <= 1'b1;
            r_we  <= i_we;
            r_adr <= i_adr;
            r_dat <= i_dat;
        end
    end

endmodule

// File: rtl/i2c_sensor_seq.sv
// Drives an I2C master core over Wishbone to run one sensor measurement:
// address+command write, repeated-start read of two bytes, with ACK and timeout handling.
module i2c_sensor_seq
    import i2c_core_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR = 7'h40,
    parameter logic [7:0]  MEAS_CMD   = 8'hE3,
    parameter logic [15:0] PRESCALE   = 16'd99,
    parameter logic [15:0] MAX_POLL   = 16'hFFFF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    output logic [4:0]  o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic        o_wb_we,
    output logic        o_wb_stb,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack,
    output logic        o_busy,
    output logic [15:0] o_data,
    output logic        o_valid,
    output logic        o_err
);

    seq_state_t  r_state;
    logic [2:0]  r_step;
    logic [15:0] r_poll_cnt;
    logic [7:0]  r_msb;
    logic        r_req;

    logic        w_ack;
    logic [7:0]  w_rdt;
    logic        w_we;
    logic [4:0]  w_adr;
    logic [7:0]  w_dat;
    logic [7:0]  w_txr;
    logic        w_tip;
    logic        w_rxack;
    logic        w_poll_expired;

    assign w_tip          = w_rdt[SR_TIP];
    assign w_rxack        = w_rdt[SR_RXACK];
    assign w_poll_expired = (r_poll_cnt == MAX_POLL - 16'd1);

    always_comb begin
        case (r_step)
            3'd0:    w_txr = {SLAVE_ADDR, 1'b0};
            3'd1:    w_txr = MEAS_CMD;
            default: w_txr = {SLAVE_ADDR, 1'b1};
        endcase
    end

    // NOTE: every output of this block gets a default first, so states that do no access cannot infer latches.
    always_comb begin
        w_we  = 1'b0;
        w_adr = '0;
        w_dat = '0;
        case (r_state)
            INIT_PRL:         begin w_we = 1'b1; w_adr = ADR_PRERLO; w_dat = PRESCALE[7:0];  end
            INIT_PRH:         begin w_we = 1'b1; w_adr = ADR_PRERHI; w_dat = PRESCALE[15:8]; end
            INIT_CTR:         begin w_we = 1'b1; w_adr = ADR_CTR;    w_dat = CTR_EN;         end
            WR_TXR:           begin w_we = 1'b1; w_adr = ADR_TXR;    w_dat = w_txr;          end
            WR_CR:            begin w_we = 1'b1; w_adr = ADR_CR;     w_dat = cr_for_step(r_step); end
            ABORT_STO:        begin w_we = 1'b1; w_adr = ADR_CR;     w_dat = CR_STO;         end
            POLL, ABORT_POLL: w_adr = ADR_CR;
            RD_RXR:           w_adr = ADR_TXR;
            default:          ;
        endcase
    end

    wb_single_master u_wb (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_req    (r_req),
        .i_we     (w_we),
        .i_adr    (w_adr),
        .i_dat    (w_dat),
        .o_ack    (w_ack),
        .o_rdt    (w_rdt),
        .o_wb_adr (o_wb_adr),
        .o_wb_dat (o_wb_dat),
        .o_wb_we  (o_wb_we),
        .o_wb_stb (o_wb_stb),
        .i_wb_rdt (i_wb_rdt),
        .i_wb_ack (i_wb_ack)
    );

    // NOTE: r_req resets high so the first INIT write is issued straight after reset release.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= INIT_PRL;
            r_step     <= '0;
            r_poll_cnt <= '0;
            r_msb      <= '0;
            r_req      <= 1'b1;
            o_busy     <= 1'b1;
            o_data     <= '0;
            o_valid    <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            r_req   <= 1'b0;
            o_valid <= 1'b0;
            o_err   <= 1'b0;
            case (r_state)
                INIT_PRL: if (w_ack) begin r_state <= INIT_PRH; r_req <= 1'b1; end
                INIT_PRH: if (w_ack) begin r_state <= INIT_CTR; r_req <= 1'b1; end
                INIT_CTR: if (w_ack) begin r_state <= IDLE; o_busy <= 1'b0; end
                IDLE: if (i_start) begin
                    r_state <= WR_TXR;
                    r_step  <= 3'd0;
                    r_req   <= 1'b1;
                    o_busy  <= 1'b1;
                end
                WR_TXR: if (w_ack) begin r_state <= WR_CR; r_req <= 1'b1; end
                WR_CR: if (w_ack) begin
                    r_state    <= POLL;
                    r_poll_cnt <= '0;
                    r_req      <= 1'b1;
                end
                POLL: if (w_ack) begin
                    if (w_tip) begin
                        if (w_poll_expired) begin
                            r_state <= IDLE;
                            o_busy  <= 1'b0;
                            o_err   <= 1'b1;
                        end else begin
                            r_poll_cnt <= r_poll_cnt + 16'd1;
                            r_req      <= 1'b1;
                        end
                    end else if (r_step < 3'd3 && w_rxack) begin
                        r_state <= ABORT_STO;
                        r_req   <= 1'b1;
                    end else if (r_step < 3'd2) begin
                        r_step  <= r_step + 3'd1;
                        r_state <= WR_TXR;
                        r_req   <= 1'b1;
                    end else if (r_step == 3'd2) begin
                        r_step  <= 3'd3;
                        r_state <= WR_CR;
                        r_req   <= 1'b1;
                    end else begin
                        r_state <= RD_RXR;
                        r_req   <= 1'b1;
                    end
                end
                RD_RXR: if (w_ack) begin
                    if (r_step == 3'd3) begin
                        r_msb   <= w_rdt;
                        r_step  <= 3'd4;
                        r_state <= WR_CR;
                        r_req   <= 1'b1;
                    end else begin
                        o_data  <= {r_msb, w_rdt};
                        o_valid <= 1'b1;
                        o_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                ABORT_STO: if (w_ack) begin
                    r_state    <= ABORT_POLL;
                    r_poll_cnt <= '0;
                    r_req      <= 1'b1;
                end
                ABORT_POLL: if (w_ack) begin
                    if (w_tip && !w_poll_expired) begin
                        r_poll_cnt <= r_poll_cnt + 16'd1;
                        r_req      <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        o_busy  <= 1'b0;
                        o_err   <= 1'b1;
                    end
                end
                default: begin r_state <= IDLE; o_busy <= 1'b0; end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_sensor_seq.sv
// Directed bench for i2c_sensor_seq against a Wishbone I2C-core slave model with
// configurable ack latency, TIP polls, RxACK and receive bytes.
module tb_i2c_sensor_seq;

    typedef struct packed { logic we; logic [4:0] adr; logic [7:0] dat; } exp_t;
    typedef struct packed { logic we; logic [4:0] adr; logic [31:0] dat; } acc_t;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        start  = 1'b0;
    logic        start2 = 1'b0;

    logic [4:0]  adr, adr2;
    logic [31:0] wdat, wdat2, rdt;
    logic        we, we2, stb, stb2, ack, ack2;
    logic [15:0] data, data2;
    logic        busy, busy2, valid, valid2, err, err2;

    int          lat = 0, tip_n = 0, rxack_at = 0;
    bit          ack_force = 1'b0, model_clr = 1'b0;
    logic [7:0]  rx_b0 = 8'h00, rx_b1 = 8'h00;

    int          wait_cnt, sr_since_cr, cr_writes, rx_idx, sr_run;
    int          len_min, len_max, valid_cnt, err_cnt, acc2_cnt, sr2_cnt, err2_cnt;
    bit          unstable, valid_busy_bad, valid_err_bad;
    logic [4:0]  hold_adr;
    logic [31:0] hold_dat;
    logic        hold_we;
    acc_t        log_q[$];
    int          run_q[$];

    int          n_tests = 0, n_fail = 0;
    exp_t        init_tab[3];
    exp_t        meas_tab[15];
    exp_t        abort_tab[5];

    always #5 clk = ~clk;

    i2c_sensor_seq dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .o_wb_adr(adr), .o_wb_dat(wdat), .o_wb_we(we), .o_wb_stb(stb),
        .i_wb_rdt(rdt), .i_wb_ack(ack),
        .o_busy(busy), .o_data(data), .o_valid(valid), .o_err(err)
    );

    i2c_sensor_seq #(.MAX_POLL(16'd4)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_start(start2),
        .o_wb_adr(adr2), .o_wb_dat(wdat2), .o_wb_we(we2), .o_wb_stb(stb2),
        .i_wb_rdt(32'h0000_0002), .i_wb_ack(ack2),
        .o_busy(busy2), .o_data(data2), .o_valid(valid2), .o_err(err2)
    );

    assign ack  = (stb && wait_cnt == lat) || ack_force;
    assign ack2 = stb2;

    always_comb begin
        rdt = '0;
        if (adr == 5'h10)
            rdt[7:0] = {(cr_writes == rxack_at), 5'd0, (sr_since_cr < tip_n), 1'b0};
        else if (adr == 5'h0C)
            rdt[7:0] = (rx_idx == 0) ? rx_b0 : rx_b1;
    end

    // Slave model: completes accesses, logs them and tracks poll runs and stb stability.
    always @(posedge clk) begin
        if (model_clr) begin
            wait_cnt <= 0; sr_since_cr <= 0; cr_writes <= 0; rx_idx <= 0; sr_run <= 0;
            len_min <= 1000; len_max <= 0; unstable <= 1'b0;
            acc2_cnt <= 0; sr2_cnt <= 0;
            log_q.delete();
            run_q.delete();
        end else begin
            if (stb && wait_cnt == 0) begin
                hold_adr <= adr; hold_dat <= wdat; hold_we <= we;
            end else if (stb && (adr != hold_adr || wdat != hold_dat || we != hold_we)) begin
                unstable <= 1'b1;
            end
            if (stb && ack) begin
                wait_cnt <= 0;
                if (wait_cnt + 1 < len_min) len_min <= wait_cnt + 1;
                if (wait_cnt + 1 > len_max) len_max <= wait_cnt + 1;
                log_q.push_back('{we: we, adr: adr, dat: wdat});
                if (we && adr == 5'h10) begin
                    sr_since_cr <= 0;
                    cr_writes   <= cr_writes + 1;
                end
                if (!we && adr == 5'h10) begin
                    sr_since_cr <= sr_since_cr + 1;
                    sr_run      <= sr_run + 1;
                end else begin
                    if (sr_run != 0) run_q.push_back(sr_run);
                    sr_run <= 0;
                end
                if (!we && adr == 5'h0C) rx_idx <= rx_idx + 1;
            end else if (stb) begin
                wait_cnt <= wait_cnt + 1;
            end else begin
                wait_cnt <= 0;
            end
            if (stb2 && ack2) begin
                acc2_cnt <= acc2_cnt + 1;
                if (!we2 && adr2 == 5'h10) sr2_cnt <= sr2_cnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (model_clr) begin
            valid_cnt <= 0; err_cnt <= 0; err2_cnt <= 0;
            valid_busy_bad <= 1'b0; valid_err_bad <= 1'b0;
        end else begin
            if (valid) valid_cnt <= valid_cnt + 1;
            if (err) err_cnt <= err_cnt + 1;
            if (err2) err2_cnt <= err2_cnt + 1;
            if (valid && busy) valid_busy_bad <= 1'b1;
            if (valid && err) valid_err_bad <= 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_entry(input string tag, input int i, input exp_t e);
        check($sformatf("%s[%0d] we", tag, i), 32'(log_q[i].we), 32'(e.we));
        check($sformatf("%s[%0d] adr", tag, i), 32'(log_q[i].adr), 32'(e.adr));
        if (e.we) check($sformatf("%s[%0d] dat", tag, i), log_q[i].dat, {24'd0, e.dat});
    endtask

    task automatic clear_model();
        @(posedge clk); #1 model_clr = 1'b1;
        @(posedge clk); #1 model_clr = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        #1;
        check({name, " idle"}, 32'(busy), 32'(1'b0));
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Release reset with a stale ack on the bus and a start request during INIT.
    task automatic release_reset(input string name);
        @(negedge clk);
        rst       = 1'b0;
        ack_force = 1'b1;
        start     = 1'b1;
        @(posedge clk);
        #1 ack_force = 1'b0;
        @(negedge clk) start = 1'b0;
        wait_idle(name, 200);
        repeat (5) @(negedge clk);
        check({name, " log len"}, 32'(log_q.size()), 32'd3);
        for (int i = 0; i < 3 && i < log_q.size(); i++) check_entry(name, i, init_tab[i]);
    endtask

    function automatic exp_t mk(input logic w, input logic [4:0] a, input logic [7:0] d);
        mk = '{we: w, adr: a, dat: d};
    endfunction

    initial begin
        init_tab  = '{mk(1, 5'h00, 8'h63), mk(1, 5'h04, 8'h00), mk(1, 5'h08, 8'h80)};
        meas_tab  = '{mk(1, 5'h0C, 8'h80), mk(1, 5'h10, 8'h90), mk(0, 5'h10, 8'h00),
                      mk(1, 5'h0C, 8'hE3), mk(1, 5'h10, 8'h10), mk(0, 5'h10, 8'h00),
                      mk(1, 5'h0C, 8'h81), mk(1, 5'h10, 8'h90), mk(0, 5'h10, 8'h00),
                      mk(1, 5'h10, 8'h20), mk(0, 5'h10, 8'h00), mk(0, 5'h0C, 8'h00),
                      mk(1, 5'h10, 8'h68), mk(0, 5'h10, 8'h00), mk(0, 5'h0C, 8'h00)};
        abort_tab = '{mk(1, 5'h0C, 8'h80), mk(1, 5'h10, 8'h90), mk(0, 5'h10, 8'h00),
                      mk(1, 5'h10, 8'h40), mk(0, 5'h10, 8'h00)};

        // Reset state
        clear_model();
        @(negedge clk);
        check("rst stb", 32'(stb), 32'd0);
        check("rst we", 32'(we), 32'd0);
        check("rst adr", 32'(adr), 32'd0);
        check("rst dat", wdat, 32'd0);
        check("rst data", 32'(data), 32'd0);
        check("rst valid/err", 32'({valid, err}), 32'd0);
        check("rst busy", 32'(busy), 32'd1);

        // INIT writes, late ack ignored, start during INIT dropped
        release_reset("init");

        // Nominal measurement
        rx_b0 = 8'h66; rx_b1 = 8'h4C;
        clear_model();
        pulse_start();
        wait_idle("meas", 500);
        check("meas log len", 32'(log_q.size()), 32'd15);
        for (int i = 0; i < 15 && i < log_q.size(); i++) check_entry("meas", i, meas_tab[i]);
        check("meas data", 32'(data), 32'h664C);
        check("meas valid cnt", 32'(valid_cnt), 32'd1);
        check("meas err cnt", 32'(err_cnt), 32'd0);
        check("meas valid w/ busy", 32'(valid_busy_bad), 32'd0);

        // NACK on address byte -> STOP, error, data kept
        rxack_at = 1;
        clear_model();
        pulse_start();
        wait_idle("abort", 500);
        check("abort log len", 32'(log_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < log_q.size(); i++) check_entry("abort", i, abort_tab[i]);
        check("abort err cnt", 32'(err_cnt), 32'd1);
        check("abort valid cnt", 32'(valid_cnt), 32'd0);
        check("abort data", 32'(data), 32'h664C);

        // Slow slave: 5-cycle ack delay, TIP busy for 3 polls
        rxack_at = 0; lat = 5; tip_n = 3;
        rx_b0 = 8'h12; rx_b1 = 8'h34;
        clear_model();
        pulse_start();
        wait_idle("slow", 3000);
        check("slow stb len min", 32'(len_min), 32'd6);
        check("slow stb len max", 32'(len_max), 32'd6);
        check("slow stb stable", 32'(unstable), 32'd0);
        check("slow poll runs", 32'(run_q.size()), 32'd5);
        foreach (run_q[i]) check($sformatf("slow run[%0d] SR reads", i), 32'(run_q[i]), 32'd4);
        check("slow data", 32'(data), 32'h1234);
        check("slow valid cnt", 32'(valid_cnt), 32'd1);
        check("valid/err overlap", 32'(valid_err_bad), 32'd0);

        // MAX_POLL=4 instance, TIP stuck; second start while busy must be dropped
        clear_model();
        check("to idle before", 32'(busy2), 32'd0);
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        repeat (3) @(negedge clk);
        start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        for (int k = 0; k < 200 && err2_cnt == 0; k++) @(negedge clk);
        #1;
        check("to err cnt", 32'(err2_cnt), 32'd1);
        check("to SR reads", 32'(sr2_cnt), 32'd4);
        check("to busy", 32'(busy2), 32'd0);
        repeat (20) @(negedge clk);
        check("to no rerun", 32'(acc2_cnt), 32'd6);

        // Reset while polling: stb drops at once, INIT restarts
        tip_n = 1000000;
        clear_model();
        pulse_start();
        for (int k = 0; k < 500 && !(stb && adr == 5'h10 && !we); k++) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst stb", 32'(stb), 32'd0);
        check("midrst busy", 32'(busy), 32'd1);
        check("midrst data", 32'(data), 32'd0);
        lat = 0; tip_n = 0;
        clear_model();
        release_reset("reinit");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
